// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in, parallel-out receiver.
package sipo_pkg;

    // Receiver FSM: waiting for a frame start, or assembling a word.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_t;

    // Bit-order select values carried on msb_first / the latched order.
    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

endpackage

// File: rtl/sipo_shift_chain.sv
// WIDTH-bit shift register with selectable direction. q_next exposes the
// value the register takes on the coming edge, so the parent can capture a
// completed word on the same edge the final bit is shifted in.
module sipo_shift_chain
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             shift_en,
    input  logic             order,
    input  logic             s_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    // Next value: left shift for MSB-first, right shift for LSB-first.
    always_comb begin
        q_next = q;
        if (shift_en) begin
            if (order == ORDER_LSB) begin
                q_next = {s_in, q[WIDTH-1:1]};
            end else begin
                q_next = {q[WIDTH-2:0], s_in};
            end
        end
    end

    // Register update; reset clears any partial word.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: framed bits are assembled into WIDTH-bit
// words and offered on a single-entry valid/ready output register.
//
// Output handshake: a word transfers on every rising edge where data_valid
// and data_ready are both 1. data holds steady while data_valid is 1 and
// data_ready is 0; data_ready is ignored while data_valid is 0.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             frame_sync,
    input  logic             msb_first,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err,
    output sipo_state_t      fsm_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    sipo_state_t      state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             order_q, order_next;
    logic             shift_en;
    logic             load, drop, ferr_next;
    logic             start, pop, dir;
    logic [WIDTH-1:0] sr_q, sr_next;

    assign start = s_valid && frame_sync;
    assign pop   = data_valid && data_ready;
    // The frame-start bit already uses the bit order presented with it.
    assign dir   = start ? msb_first : order_q;

    sipo_shift_chain #(.WIDTH(WIDTH)) u_chain (
        .clk        (clk),
        .sync_reset (sync_reset),
        .shift_en   (shift_en),
        .order      (dir),
        .s_in       (s_in),
        .q          (sr_q),
        .q_next     (sr_next)
    );

    // Next-state logic: frame start, bit accumulation, completion, restart.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        order_next = order_q;
        shift_en   = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;
        ferr_next  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    shift_en   = 1'b1;
                    order_next = msb_first;
                    cnt_next   = CW'(1);
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (s_valid) begin
                    shift_en = 1'b1;
                    if (frame_sync) begin
                        // Mid-word sync: drop the partial word, restart here.
                        ferr_next  = 1'b1;
                        order_next = msb_first;
                        cnt_next   = CW'(1);
                    end else if (cnt == LAST_CNT) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                        if (!data_valid || pop) begin
                            load = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counter, holding register and flag registers.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            order_q    <= ORDER_MSB;
            data       <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            order_q   <= order_next;
            frame_err <= ferr_next;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (load) begin
                data       <= sr_next;
                data_valid <= 1'b1;
            end else if (pop) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy      = (state == ST_SHIFT);
    assign fsm_state = state;

endmodule
